// File: rtl/countdown_chain_if.sv
// ---------------------------------------------------------------------------
// countdown_chain_if
// Control/data bundle between the timer controller and countdown_chain.
//   loadn   : synchronous active-low load strobe
//   data    : BCD load value, nibble i -> digit i
//   en      : tick strobe from the 1 Hz tick generator
//   start   : request RUN
//   pause   : request PAUSED
//   up      : count direction (only with COUNTDOWN_CHAIN_UP_EN defined)
//   digits  : current BCD value, to the 7-segment driver
//   zero    : all digits are 0 (combinational)
//   tc      : one-cycle pulse on entry to DONE
//   running : block is in RUN
// Modports: master drives the controls, slave is the counter.
// ---------------------------------------------------------------------------
interface countdown_chain_if #(
    parameter int NDIGITS = 4
);
    logic                   loadn;
    logic [4*NDIGITS-1:0]   data;
    logic                   en;
    logic                   start;
    logic                   pause;
`ifdef COUNTDOWN_CHAIN_UP_EN
    logic                   up;
`endif
    logic [4*NDIGITS-1:0]   digits;
    logic                   zero;
    logic                   tc;
    logic                   running;

    modport master (
        output loadn, data, en, start, pause,
`ifdef COUNTDOWN_CHAIN_UP_EN
        output up,
`endif
        input  digits, zero, tc, running
    );

    modport slave (
        input  loadn, data, en, start, pause,
`ifdef COUNTDOWN_CHAIN_UP_EN
        input  up,
`endif
        output digits, zero, tc, running
    );
endinterface

// File: rtl/countdown_chain.sv
// ---------------------------------------------------------------------------
// countdown_chain
// Cascade of NDIGITS BCD digits counting down on a shared tick enable, each
// digit with its own maximum (DIGIT_MAX nibble i). The default configuration
// is an MM:SS timer (59:59). Run control is IDLE/RUN/PAUSED/DONE. DONE holds
// at 00:00 and emits a one-cycle tc pulse on entry.
//
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : countdown_chain_if.slave (load/tick/run controls, digits/status)
//
// Optional feature, macro COUNTDOWN_CHAIN_UP_EN: adds bus.up. While RUN with
// up=1 a tick counts up with carry, and reaching all-max ends in DONE.
//
// Per-cycle priority: clear > load > pause > start > tick.
// ---------------------------------------------------------------------------

// One digit: steps when it receives a borrow/carry. bnd_o reports that the
// digit sits at its wrap boundary, so the next digit up receives the step.
module countdown_chain_digit (
    input  logic [3:0] val_i,
    input  logic [3:0] max_i,
    input  logic       step_i,
    input  logic       up_i,
    output logic [3:0] nxt_o,
    output logic       bnd_o
);
    always_comb begin
        bnd_o = up_i ? (val_i == max_i) : (val_i == 4'd0);
        nxt_o = val_i;
        if (step_i) begin
            if (up_i) nxt_o = bnd_o ? 4'd0  : val_i + 4'd1;
            else      nxt_o = bnd_o ? max_i : val_i - 4'd1;
        end
    end
endmodule

module countdown_chain #(
    parameter int                   NDIGITS   = 4,
    parameter logic [4*NDIGITS-1:0] DIGIT_MAX = 16'h5959
) (
    input  logic                 clock,
    input  logic                 clear,
    countdown_chain_if.slave     bus
);
    localparam int W = 4 * NDIGITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   digits_q, digits_d;
    logic           tc_q, tc_d;

    logic           up_w;
    logic [W-1:0]   load_val;   // data with each nibble clamped to its max
    logic [W-1:0]   step_val;   // value after one tick in the current direction
    logic [W-1:0]   end_val;    // terminal value: 0 counting down, all-max up
    logic [NDIGITS:0] step_chain;
    logic [NDIGITS-1:0] bnd;

`ifdef COUNTDOWN_CHAIN_UP_EN
    assign up_w = bus.up;
`else
    assign up_w = 1'b0;
`endif

    // Digit 0 always steps; digit i steps when every lower digit is at its
    // boundary (0 down, max up).
    assign step_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_dig
            localparam logic [3:0] DMAX = DIGIT_MAX[4*gi +: 4];

            assign load_val[4*gi +: 4] =
                (bus.data[4*gi +: 4] > DMAX) ? DMAX : bus.data[4*gi +: 4];

            countdown_chain_digit u_digit (
                .val_i  (digits_q[4*gi +: 4]),
                .max_i  (DMAX),
                .step_i (step_chain[gi]),
                .up_i   (up_w),
                .nxt_o  (step_val[4*gi +: 4]),
                .bnd_o  (bnd[gi])
            );

            assign step_chain[gi+1] = step_chain[gi] & bnd[gi];
        end
    endgenerate

    // The start guard and the DONE target follow the sampled direction, so
    // a value already at the terminal count never enters RUN.
    assign end_val = up_w ? DIGIT_MAX : '0;

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        tc_d     = 1'b0;
        if (!bus.loadn) begin
            digits_d = load_val;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.pause && bus.start && (digits_q != end_val))
                        state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                    end else if (bus.en) begin
                        digits_d = step_val;
                        if (step_val == end_val) begin
                            state_d = S_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.pause && bus.start)
                        state_d = S_RUN;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.zero    = (digits_q == '0);
    assign bus.tc      = tc_q;
    assign bus.running = (state_q == S_RUN);
endmodule

// File: tb/tb_countdown_chain.sv
module tb_countdown_chain;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    countdown_chain_if #(.NDIGITS(4)) bus ();

    countdown_chain #(.NDIGITS(4), .DIGIT_MAX(16'h5959)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.loadn = 1'b1;
        bus.data  = 16'h0000;
        bus.en    = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
`ifdef COUNTDOWN_CHAIN_UP_EN
        bus.up    = 1'b0;
`endif
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.loadn = 1'b0;
        bus.data  = v;
        cyc();
        bus.loadn = 1'b1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_tick();
        bus.en = 1'b1;
        cyc();
        bus.en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clear = 1'b1;
        cyc();
        checks++;
        if (bus.digits !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", bus.digits); end
        checks++;
        if (bus.zero !== 1'b1 || bus.tc !== 1'b0 || bus.running !== 1'b0) begin
            errors++; $display("FAIL reset_flags: zero=%b tc=%b run=%b want 1 0 0", bus.zero, bus.tc, bus.running);
        end
        clear = 1'b0;
        cyc();
    endtask

    task automatic test_load_clamp();
        do_load(16'h1000);
        checks++;
        if (bus.digits !== 16'h1000) begin errors++; $display("FAIL load_1000: got %h want 1000", bus.digits); end
        do_start();
        checks++;
        if (bus.running !== 1'b1) begin errors++; $display("FAIL start_run: got %b want 1", bus.running); end
        do_tick();
        checks++;
        if (bus.digits !== 16'h0959) begin errors++; $display("FAIL borrow_1000: got %h want 0959", bus.digits); end
        do_tick();
        checks++;
        if (bus.digits !== 16'h0958) begin errors++; $display("FAIL tick_0959: got %h want 0958", bus.digits); end
        do_load(16'hFF7C);
        checks++;
        if (bus.digits !== 16'h5959 || bus.running !== 1'b0) begin
            errors++; $display("FAIL clamp_FF7C: got %h run=%b want 5959 run=0", bus.digits, bus.running);
        end
        do_load(16'h0100);
        do_start();
        do_tick();
        checks++;
        if (bus.digits !== 16'h0059) begin errors++; $display("FAIL borrow_0100: got %h want 0059", bus.digits); end
    endtask

    task automatic test_done();
        do_load(16'h0003);
        do_start();
        do_tick();
        checks++;
        if (bus.digits !== 16'h0002 || bus.tc !== 1'b0) begin errors++; $display("FAIL done_t1: got %h tc=%b want 0002 tc=0", bus.digits, bus.tc); end
        do_tick();
        checks++;
        if (bus.digits !== 16'h0001) begin errors++; $display("FAIL done_t2: got %h want 0001", bus.digits); end
        do_tick();
        checks++;
        if (bus.digits !== 16'h0000 || bus.tc !== 1'b1 || bus.running !== 1'b0 || bus.zero !== 1'b1) begin
            errors++; $display("FAIL done_entry: got %h tc=%b run=%b zero=%b want 0000 1 0 1", bus.digits, bus.tc, bus.running, bus.zero);
        end
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_tick();
            checks++;
            if (bus.digits !== 16'h0000 || bus.tc !== 1'b0 || bus.running !== 1'b0) begin
                errors++; $display("FAIL done_hold%0d: got %h tc=%b run=%b want 0000 0 0", i, bus.digits, bus.tc, bus.running);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_pause();
        do_load(16'h0010);
        do_start();
        bus.pause = 1'b1;
        bus.en    = 1'b1;
        cyc();
        bus.pause = 1'b0;
        bus.en    = 1'b0;
        checks++;
        if (bus.digits !== 16'h0010 || bus.running !== 1'b0) begin
            errors++; $display("FAIL pause_tick: got %h run=%b want 0010 run=0", bus.digits, bus.running);
        end
        for (int i = 0; i < 4; i++) do_tick();
        checks++;
        if (bus.digits !== 16'h0010) begin errors++; $display("FAIL paused_hold: got %h want 0010", bus.digits); end
        bus.start = 1'b1;
        bus.pause = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.pause = 1'b0;
        checks++;
        if (bus.running !== 1'b0) begin errors++; $display("FAIL pause_wins: run=%b want 0", bus.running); end
        do_start();
        do_tick();
        checks++;
        if (bus.digits !== 16'h0009 || bus.running !== 1'b1) begin
            errors++; $display("FAIL resume: got %h run=%b want 0009 run=1", bus.digits, bus.running);
        end
    endtask

    task automatic test_idle_zero();
        do_load(16'h0000);
        do_start();
        checks++;
        if (bus.running !== 1'b0) begin errors++; $display("FAIL start_at_zero: run=%b want 0", bus.running); end
        bus.start = 1'b1;
        do_load(16'h0001);
        bus.start = 1'b0;
        checks++;
        if (bus.digits !== 16'h0001 || bus.running !== 1'b0) begin
            errors++; $display("FAIL load_over_start: got %h run=%b want 0001 run=0", bus.digits, bus.running);
        end
    endtask

    task automatic test_clear_mid();
        do_load(16'h0328);
        do_start();
        do_tick();
        checks++;
        if (bus.digits !== 16'h0327 || bus.running !== 1'b1) begin
            errors++; $display("FAIL pre_clear: got %h run=%b want 0327 run=1", bus.digits, bus.running);
        end
        clear = 1'b1;
        #1;
        checks++;
        if (bus.digits !== 16'h0000 || bus.running !== 1'b0 || bus.tc !== 1'b0 || bus.zero !== 1'b1) begin
            errors++; $display("FAIL async_clear: got %h run=%b tc=%b zero=%b want 0000 0 0 1", bus.digits, bus.running, bus.tc, bus.zero);
        end
        cyc();
        clear = 1'b0;
        cyc();
    endtask

`ifdef COUNTDOWN_CHAIN_UP_EN
    task automatic test_up();
        bus.up = 1'b1;
        do_load(16'h5958);
        do_start();
        do_tick();
        checks++;
        if (bus.digits !== 16'h5959 || bus.tc !== 1'b1 || bus.running !== 1'b0) begin
            errors++; $display("FAIL up_done: got %h tc=%b run=%b want 5959 1 0", bus.digits, bus.tc, bus.running);
        end
        do_load(16'h0059);
        do_start();
        do_tick();
        checks++;
        if (bus.digits !== 16'h0100) begin errors++; $display("FAIL up_carry: got %h want 0100", bus.digits); end
        bus.up = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_clamp();
        test_done();
        test_pause();
        test_idle_zero();
        test_clear_mid();
`ifdef COUNTDOWN_CHAIN_UP_EN
        test_up();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
